data_mem_arbiter: RTL and testbench

Shares the single-port data RAM between the pipelined processor's memory stage and an external host loader (UART or JTAG image loader) that bursts plaintext or ciphertext words in and out. The CPU has default priority. A host burst owns the RAM for its whole length, and the CPU is stalled while it runs. A starvation counter guarantees the host eventually gets the RAM. The block sits between the processor's MemWrite/ALUResult/WriteData/ReadData signals and the RAM macro.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_starve_counter.sv | 32 +++
 rtl/data_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-RAM arbiter.
//   arb_state_t : arbiter FSM states (CPU-owned idle, host write burst, host read burst)
//   owner_t     : who drove the RAM port in a given cycle
//   WORD_BYTES  : byte stride between consecutive burst beats
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOST_WR = 2'd1,
        HOST_RD = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive cycles in which a waiting host was denied.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   inc        : count one more denied cycle (ignored once saturated)
//   clear      : return to zero (host gave up or was granted)
//   atLimit    : counter has reached LIMIT; the host must be let in
module arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic atLimit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign atLimit = (count == CW'(LIMIT));

    // Clear wins over increment so a grant in the same cycle restarts the count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !atLimit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU memory stage (default
// priority) and a host burst loader. A granted host burst owns the RAM for its
// whole length while the CPU is stalled; a starvation counter forces the host
// in after STARVE_LIMIT consecutive denied cycles.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_rdata    : CPU memory-stage access and load data
//   cpu_stall                           : CPU must hold its access (host owns RAM)
//   host_req/we/addr/len, host_gnt      : burst descriptor and latch pulse
//   host_wvalid/wdata, host_wready      : write-beat handshake
//   host_rvalid/rdata                   : read-beat data, one cycle after issue
//   host_done                           : pulse when the last beat completes
//   mem_we/addr/wdata, mem_rdata        : RAM macro port (1-cycle read latency)
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LEN_W-1:0]  host_len,
    output logic              host_gnt,
    input  logic              host_wvalid,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_wready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, stateNext;
    owner_t            prevOwner;
    logic [ADDR_W-1:0] curAddr;
    logic [LEN_W-1:0]  remaining;
    logic              rdPending;
    logic              rdLast;
    logic              grant;
    logic              beat;
    logic              lastBeat;
    logic              atLimit;
    logic              starveInc;
    logic              starveClear;

    assign lastBeat    = (remaining == LEN_W'(1));
    assign starveInc   = (state == IDLE) && host_req && cpu_req && !grant;
    assign starveClear = !host_req || grant;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) uStarve (
        .clk     (clk),
        .reset   (reset),
        .inc     (starveInc),
        .clear   (starveClear),
        .atLimit (atLimit)
    );

    // Next state and RAM-port steering. While reset is asserted every output is
    // held at zero so an aborted burst cannot write, return data or signal done.
    always_comb begin
        stateNext   = state;
        grant       = 1'b0;
        beat        = 1'b0;
        cpu_stall   = 1'b0;
        host_gnt    = 1'b0;
        host_wready = 1'b0;
        host_rvalid = rdPending;
        host_rdata  = rdPending ? mem_rdata : '0;
        host_done   = rdLast;
        cpu_rdata   = (prevOwner == OWN_CPU) ? mem_rdata : '0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        if (reset) begin
            stateNext   = IDLE;
            host_rvalid = 1'b0;
            host_rdata  = '0;
            host_done   = 1'b0;
            cpu_rdata   = '0;
        end else begin
            case (state)
                IDLE: begin
                    // The CPU is served even in the cycle the host is granted.
                    mem_addr  = cpu_addr;
                    mem_we    = cpu_req & cpu_we;
                    mem_wdata = cpu_wdata;
                    grant     = host_req && (!cpu_req || atLimit);
                    host_gnt  = grant;
                    if (grant) begin
                        stateNext = host_we ? HOST_WR : HOST_RD;
                    end
                end
                HOST_WR: begin
                    cpu_stall   = cpu_req;
                    host_wready = 1'b1;
                    mem_addr    = curAddr;
                    mem_wdata   = host_wdata;
                    mem_we      = host_wvalid;
                    beat        = host_wvalid;
                    if (host_wvalid && lastBeat) begin
                        host_done = 1'b1;
                        stateNext = IDLE;
                    end
                end
                HOST_RD: begin
                    cpu_stall = cpu_req;
                    mem_addr  = curAddr;
                    beat      = 1'b1;
                    if (lastBeat) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Burst bookkeeping. A zero length is loaded as one beat; the address
    // advances by a word per beat and simply wraps at the top of the space.
    // rdPending/rdLast delay the read issue by the RAM's one-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prevOwner <= OWN_HOST;
            curAddr   <= '0;
            remaining <= '0;
            rdPending <= 1'b0;
            rdLast    <= 1'b0;
        end else begin
            state     <= stateNext;
            prevOwner <= (state == IDLE) ? OWN_CPU : OWN_HOST;
            rdPending <= (state == HOST_RD);
            rdLast    <= (state == HOST_RD) && lastBeat;
            if (grant) begin
                curAddr   <= host_addr;
                remaining <= (host_len == '0) ? LEN_W'(1) : host_len;
            end else if (beat) begin
                curAddr   <= curAddr + ADDR_W'(WORD_BYTES);
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a table of per-cycle vectors for
// CPU traffic and a simple host write burst, then hand-written sequences for
// starvation, write backpressure, address wrap, zero length and mid-burst reset.
module tb_data_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic        cReq;
        logic        cWe;
        logic [31:0] cAddr;
        logic [31:0] cWdata;
        logic        hReq;
        logic        hWe;
        logic [31:0] hAddr;
        logic [4:0]  hLen;
        logic        hWvalid;
        logic [31:0] hWdata;
        logic        eStall;
        logic        eGnt;
        logic        eWready;
        logic        eWe;
        logic        eDone;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [31:0] eCpuRdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq, cpuWe, cpuStall;
    logic [31:0] cpuAddr, cpuWdata, cpuRdata;
    logic        hostReq, hostWe, hostGnt, hostWvalid, hostWready, hostRvalid, hostDone;
    logic [31:0] hostAddr, hostWdata, hostRdata;
    logic [4:0]  hostLen;
    logic        memWe;
    logic [31:0] memAddr, memWdata, memRdata;

    logic [31:0] ram [1024];
    vec_t        vecs [11];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpuReq),
        .cpu_we      (cpuWe),
        .cpu_addr    (cpuAddr),
        .cpu_wdata   (cpuWdata),
        .cpu_rdata   (cpuRdata),
        .cpu_stall   (cpuStall),
        .host_req    (hostReq),
        .host_we     (hostWe),
        .host_addr   (hostAddr),
        .host_len    (hostLen),
        .host_gnt    (hostGnt),
        .host_wvalid (hostWvalid),
        .host_wdata  (hostWdata),
        .host_wready (hostWready),
        .host_rvalid (hostRvalid),
        .host_rdata  (hostRdata),
        .host_done   (hostDone),
        .mem_we      (memWe),
        .mem_addr    (memAddr),
        .mem_wdata   (memWdata),
        .mem_rdata   (memRdata)
    );

    // Word RAM model with one-cycle read latency (read returns pre-write data).
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            memRdata <= '0;
        end else begin
            memRdata <= ram[memAddr[11:2]];
            if (memWe) ram[memAddr[11:2]] <= memWdata;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(
        input logic cReq, input logic cWe, input logic [31:0] cAddr, input logic [31:0] cWdata,
        input logic hReq, input logic hWe, input logic [31:0] hAddr, input logic [4:0] hLen,
        input logic hWvalid, input logic [31:0] hWdata,
        input logic eStall, input logic eGnt, input logic eWready, input logic eWe, input logic eDone,
        input logic [31:0] eAddr, input logic [31:0] eWdata, input logic [31:0] eCpuRdata);
        vec_t v;
        v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr; v.cWdata = cWdata;
        v.hReq = hReq; v.hWe = hWe; v.hAddr = hAddr; v.hLen = hLen;
        v.hWvalid = hWvalid; v.hWdata = hWdata;
        v.eStall = eStall; v.eGnt = eGnt; v.eWready = eWready; v.eWe = eWe; v.eDone = eDone;
        v.eAddr = eAddr; v.eWdata = eWdata; v.eCpuRdata = eCpuRdata;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
        hostReq = 1'b0; hostWe = 1'b0; hostAddr = '0; hostLen = '0;
        hostWvalid = 1'b0; hostWdata = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        cpuReq = v.cReq; cpuWe = v.cWe; cpuAddr = v.cAddr; cpuWdata = v.cWdata;
        hostReq = v.hReq; hostWe = v.hWe; hostAddr = v.hAddr; hostLen = v.hLen;
        hostWvalid = v.hWvalid; hostWdata = v.hWdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, ".memWe"}, memWe, L);
        checkOutput({tag, ".memAddr"}, memAddr, 32'h0);
        checkOutput({tag, ".memWdata"}, memWdata, 32'h0);
        checkBit({tag, ".stall"}, cpuStall, L);
        checkOutput({tag, ".cpuRdata"}, cpuRdata, 32'h0);
        checkBit({tag, ".gnt"}, hostGnt, L);
        checkBit({tag, ".wready"}, hostWready, L);
        checkBit({tag, ".rvalid"}, hostRvalid, L);
        checkOutput({tag, ".rdata"}, hostRdata, 32'h0);
        checkBit({tag, ".done"}, hostDone, L);
    endtask

    initial begin
        int  denied;
        bit  gotGnt;

        vecs[0]  = mkVec(H, H, 32'h40, 32'hDEADBEEF, L, L, 32'h0, 5'd0, L, 32'h0,
                         L, L, L, H, L, 32'h40, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mkVec(H, L, 32'h40, 32'h0, L, L, 32'h0, 5'd0, L, 32'h0,
                         L, L, L, L, L, 32'h40, 32'h0, 32'h0);
        vecs[2]  = mkVec(L, L, 32'h0, 32'h0, L, L, 32'h0, 5'd0, L, 32'h0,
                         L, L, L, L, L, 32'h0, 32'h0, 32'hDEADBEEF);
        vecs[3]  = mkVec(L, L, 32'h0, 32'h0, H, H, 32'h100, 5'd4, L, 32'h0,
                         L, H, L, L, L, 32'h0, 32'h0, 32'h0);
        vecs[4]  = mkVec(L, L, 32'h0, 32'h0, L, L, 32'h0, 5'd0, H, 32'h1,
                         L, L, H, H, L, 32'h100, 32'h1, 32'h0);
        vecs[5]  = mkVec(L, L, 32'h0, 32'h0, L, L, 32'h0, 5'd0, H, 32'h2,
                         L, L, H, H, L, 32'h104, 32'h2, 32'h0);
        vecs[6]  = mkVec(L, L, 32'h0, 32'h0, L, L, 32'h0, 5'd0, H, 32'h3,
                         L, L, H, H, L, 32'h108, 32'h3, 32'h0);
        vecs[7]  = mkVec(L, L, 32'h0, 32'h0, L, L, 32'h0, 5'd0, H, 32'h4,
                         L, L, H, H, H, 32'h10C, 32'h4, 32'h0);
        vecs[8]  = mkVec(H, L, 32'h104, 32'h0, L, L, 32'h0, 5'd0, L, 32'h0,
                         L, L, L, L, L, 32'h104, 32'h0, 32'h0);
        vecs[9]  = mkVec(H, L, 32'h10C, 32'h0, L, L, 32'h0, 5'd0, L, 32'h0,
                         L, L, L, L, L, 32'h10C, 32'h0, 32'h2);
        vecs[10] = mkVec(L, L, 32'h0, 32'h0, L, L, 32'h0, 5'd0, L, 32'h0,
                         L, L, L, L, L, 32'h0, 32'h0, 32'h4);

        // Reset
        setIdle();
        reset = 1'b1;
        tick();
        #2;
        checkAllZero("reset");
        tick();
        reset = 1'b0;

        // Table: CPU store/load, then a 4-beat host write with the CPU idle
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkBit($sformatf("v%0d.stall", i), cpuStall, vecs[i].eStall);
            checkBit($sformatf("v%0d.gnt", i), hostGnt, vecs[i].eGnt);
            checkBit($sformatf("v%0d.wready", i), hostWready, vecs[i].eWready);
            checkBit($sformatf("v%0d.memWe", i), memWe, vecs[i].eWe);
            checkBit($sformatf("v%0d.done", i), hostDone, vecs[i].eDone);
            checkBit($sformatf("v%0d.rvalid", i), hostRvalid, L);
            checkOutput($sformatf("v%0d.memAddr", i), memAddr, vecs[i].eAddr);
            checkOutput($sformatf("v%0d.memWdata", i), memWdata, vecs[i].eWdata);
            checkOutput($sformatf("v%0d.cpuRdata", i), cpuRdata, vecs[i].eCpuRdata);
            tick();
        end

        // Host read while the CPU is continuously busy: starvation forces the grant
        setIdle();
        cpuReq = 1'b1; cpuAddr = 32'h40;
        hostReq = 1'b1; hostWe = 1'b0; hostAddr = 32'h100; hostLen = 5'd3;
        denied = 0;
        gotGnt = 1'b0;
        for (int c = 0; c < 20 && !gotGnt; c++) begin
            #2;
            if (hostGnt) begin
                gotGnt = 1'b1;
            end else begin
                denied++;
                if (cpuStall || memAddr != 32'h40) checkBit("starveCpuServed", L, H);
                tick();
            end
        end
        if (!gotGnt) begin
            checkOutput("starveGrantTimeout", 32'h0, 32'h1);
        end else begin
            checkOutput("starveDenied", denied, 32'd8);
            checkOutput("starveGrantCpuAddr", memAddr, 32'h40);
            checkBit("starveGrantStall", cpuStall, L);
        end
        tick();
        hostReq = 1'b0;
        #2;
        checkBit("rd1.stall", cpuStall, H);
        checkOutput("rd1.memAddr", memAddr, 32'h100);
        checkBit("rd1.memWe", memWe, L);
        checkBit("rd1.rvalid", hostRvalid, L);
        tick();
        #2;
        checkBit("rd2.stall", cpuStall, H);
        checkOutput("rd2.memAddr", memAddr, 32'h104);
        checkBit("rd2.rvalid", hostRvalid, H);
        checkOutput("rd2.rdata", hostRdata, 32'h1);
        checkBit("rd2.done", hostDone, L);
        tick();
        #2;
        checkBit("rd3.stall", cpuStall, H);
        checkOutput("rd3.memAddr", memAddr, 32'h108);
        checkBit("rd3.rvalid", hostRvalid, H);
        checkOutput("rd3.rdata", hostRdata, 32'h2);
        checkBit("rd3.done", hostDone, L);
        tick();
        #2;
        checkBit("rd4.stall", cpuStall, L);
        checkOutput("rd4.memAddr", memAddr, 32'h40);
        checkBit("rd4.rvalid", hostRvalid, H);
        checkOutput("rd4.rdata", hostRdata, 32'h3);
        checkBit("rd4.done", hostDone, H);
        tick();
        #2;
        checkBit("rd5.rvalid", hostRvalid, L);
        checkBit("rd5.done", hostDone, L);
        checkOutput("rd5.cpuRdata", cpuRdata, 32'hDEADBEEF);
        tick();

        // Write burst with wvalid gaps
        setIdle();
        hostReq = 1'b1; hostWe = 1'b1; hostAddr = 32'h200; hostLen = 5'd2;
        #2;
        checkBit("bp.gnt", hostGnt, H);
        tick();
        hostReq = 1'b0;
        hostWvalid = 1'b1; hostWdata = 32'hA1;
        #2;
        checkBit("bp1.memWe", memWe, H);
        checkOutput("bp1.memAddr", memAddr, 32'h200);
        checkOutput("bp1.memWdata", memWdata, 32'hA1);
        checkBit("bp1.done", hostDone, L);
        tick();
        hostWvalid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            #2;
            checkBit($sformatf("bpGap%0d.memWe", g), memWe, L);
            checkBit($sformatf("bpGap%0d.wready", g), hostWready, H);
            checkBit($sformatf("bpGap%0d.done", g), hostDone, L);
            tick();
        end
        hostWvalid = 1'b1; hostWdata = 32'hA2;
        #2;
        checkBit("bp2.memWe", memWe, H);
        checkOutput("bp2.memAddr", memAddr, 32'h204);
        checkBit("bp2.done", hostDone, H);
        tick();
        #2;
        checkBit("bpAfter.wready", hostWready, L);
        checkBit("bpAfter.memWe", memWe, L);
        tick();
        hostWvalid = 1'b0;
        checkOutput("bpRam200", ram[128], 32'hA1);
        checkOutput("bpRam204", ram[129], 32'hA2);
        checkOutput("bpRam208", ram[130], 32'h0);

        // Address wrap, then a zero-length burst
        setIdle();
        hostReq = 1'b1; hostWe = 1'b1; hostAddr = 32'hFFFFFFFC; hostLen = 5'd2;
        #2;
        checkBit("wrap.gnt", hostGnt, H);
        tick();
        hostReq = 1'b0;
        hostWvalid = 1'b1; hostWdata = 32'h55;
        #2;
        checkOutput("wrap1.memAddr", memAddr, 32'hFFFFFFFC);
        checkBit("wrap1.memWe", memWe, H);
        checkBit("wrap1.done", hostDone, L);
        tick();
        hostWdata = 32'h66;
        #2;
        checkOutput("wrap2.memAddr", memAddr, 32'h0);
        checkBit("wrap2.memWe", memWe, H);
        checkBit("wrap2.done", hostDone, H);
        tick();
        setIdle();
        hostReq = 1'b1; hostWe = 1'b1; hostAddr = 32'h300; hostLen = 5'd0;
        #2;
        checkBit("len0.gnt", hostGnt, H);
        tick();
        hostReq = 1'b0;
        hostWvalid = 1'b1; hostWdata = 32'h77;
        #2;
        checkOutput("len0.memAddr", memAddr, 32'h300);
        checkBit("len0.memWe", memWe, H);
        checkBit("len0.done", hostDone, H);
        tick();
        #2;
        checkBit("len0After.wready", hostWready, L);
        checkBit("len0After.memWe", memWe, L);
        tick();
        setIdle();

        // Reset in the middle of an 8-beat read
        hostReq = 1'b1; hostWe = 1'b0; hostAddr = 32'h100; hostLen = 5'd8;
        #2;
        checkBit("rst.gnt", hostGnt, H);
        tick();
        hostReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput($sformatf("rstIssue%0d.memAddr", i), memAddr, 32'h100 + 32'(4 * i));
            checkBit($sformatf("rstIssue%0d.rvalid", i), hostRvalid, (i > 0));
            tick();
        end
        reset = 1'b1;
        #2;
        checkAllZero("rstAssert");
        tick();
        reset = 1'b0;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'h80; cpuWdata = 32'h1234;
        #2;
        checkBit("rstAfter.stall", cpuStall, L);
        checkBit("rstAfter.memWe", memWe, H);
        checkOutput("rstAfter.memAddr", memAddr, 32'h80);
        checkOutput("rstAfter.memWdata", memWdata, 32'h1234);
        checkBit("rstAfter.rvalid", hostRvalid, L);
        checkBit("rstAfter.done", hostDone, L);
        checkOutput("rstAfter.cpuRdata", cpuRdata, 32'h0);
        tick();
        setIdle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
